apb_master: RTL and testbench

//   APB requester driving the shared APB bus toward slave1/slave2.

---
 rtl/apb_master.sv | 84 ++++++++
 tb/tb_apb_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester for two slaves with a wait-state timeout.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W:0]   cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nx;
    logic sel_q;
    logic [7:0] wait_cnt;
    logic accept, done, abort;
    assign accept = cmd_valid && cmd_ready;
    assign done   = (state == ACCESS) && PREADY;
    // the wait that would take the counter to TIMEOUT aborts, unless PREADY arrives on that same edge
    assign abort  = (state == ACCESS) && !PREADY && (TIMEOUT != 0) && (int'(wait_cnt) + 1 == TIMEOUT);
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE)   ? (accept ? SETUP : IDLE) :
                   (state == SETUP)  ? ACCESS :
                   (state == ACCESS && !done && !abort) ? ACCESS : IDLE;
    end
    always_comb begin
        cmd_ready = (state == IDLE) && !PRESET;
        PSEL1     = (state == SETUP || state == ACCESS) && !sel_q;
        PSEL2     = (state == SETUP || state == ACCESS) && sel_q;
        PENABLE   = (state == ACCESS);
    end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sel_q    <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            wait_cnt <= '0;
        end else if (accept) begin
            sel_q    <= cmd_addr[ADDR_W];
            PWRITE   <= cmd_write;
            PADDR    <= cmd_addr[ADDR_W-1:0];
            PWDATA   <= cmd_wdata;
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done || abort;
            if (done) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= PWRITE ? '0 : (sel_q ? PRDATA2 : PRDATA1);
            end else if (abort) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized and directed checks of apb_master against a transaction-level model.
module tb_apb_master;
    localparam int TO = 16;
    logic       PCLK = 1'b0, PRESET = 1'b1;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [8:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, PSEL1, PSEL2, PENABLE, PWRITE, PREADY, rsp_valid, rsp_err;
    logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2, rsp_rdata;
    int n_chk = 0, n_fail = 0;

    apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
        .PREADY(PREADY), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] iv(int s, int i);
        return 8'(s * 91 + i * 37 + 5);
    endfunction

    function automatic int pick();
        int r = int'($urandom_range(9));
        return r < 6 ? r % 4 : r == 6 ? 14 : r == 7 ? 15 : r == 8 ? 16 : 255;
    endfunction

    // bus slaves: 64-entry memories, PREADY after a chosen number of ACCESS wait cycles
    logic [7:0] slv_mem [2][64];
    logic rand_mode = 1'b0;
    int   fix_wait = 0, slv_wait = 0, slv_cnt = 0;
    assign PRDATA1 = slv_mem[0][PADDR[5:0]];
    assign PRDATA2 = slv_mem[1][PADDR[5:0]];
    assign PREADY  = (PSEL1 || PSEL2) && PENABLE && (slv_cnt >= slv_wait);
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int s = 0; s < 2; s++) for (int i = 0; i < 64; i++) slv_mem[s][i] <= iv(s, i);
            slv_cnt <= 0;
        end else begin
            if ((PSEL1 || PSEL2) && !PENABLE) begin
                slv_cnt  <= 0;
                slv_wait <= rand_mode ? pick() : fix_wait;
            end else if (PENABLE) slv_cnt <= slv_cnt + 1;
            if (PSEL1 && PENABLE && PREADY && PWRITE) slv_mem[0][PADDR[5:0]] <= PWDATA;
            if (PSEL2 && PENABLE && PREADY && PWRITE) slv_mem[1][PADDR[5:0]] <= PWDATA;
        end
    end

    // transaction-level reference: one command in flight, one setup cycle, then waits until ready or timeout
    logic [7:0] ref_mem [2][64];
    logic m_busy, m_setup, m_sel, m_write, m_rv, m_re;
    logic [7:0] m_addr, m_wdata, m_rd;
    int m_waits;
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int s = 0; s < 2; s++) for (int i = 0; i < 64; i++) ref_mem[s][i] = iv(s, i);
            m_busy = 0; m_setup = 0; m_sel = 0; m_write = 0; m_addr = 0; m_wdata = 0;
            m_rv = 0; m_rd = 0; m_re = 0; m_waits = 0;
        end else begin
            m_rv = 0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy = 1; m_setup = 1; m_waits = 0;
                    m_sel = cmd_addr[8]; m_addr = cmd_addr[7:0]; m_write = cmd_write; m_wdata = cmd_wdata;
                end
            end else if (m_setup) m_setup = 0;
            else if (PREADY) begin
                m_busy = 0; m_rv = 1; m_re = 0;
                m_rd = m_write ? 8'h00 : ref_mem[m_sel][m_addr[5:0]];
                if (m_write) ref_mem[m_sel][m_addr[5:0]] = m_wdata;
            end else begin
                m_waits++;
                if (TO != 0 && m_waits == TO) begin
                    m_busy = 0; m_rv = 1; m_re = 1; m_rd = 0;
                end
            end
        end
    end

    always @(negedge PCLK) begin
        chk("cmd_ready", cmd_ready, !m_busy && !PRESET);
        chk("PSEL1", PSEL1, m_busy && !m_sel);
        chk("PSEL2", PSEL2, m_busy && m_sel);
        chk("PENABLE", PENABLE, m_busy && !m_setup);
        chk("PADDR", PADDR, m_addr);
        chk("PWRITE", PWRITE, m_write);
        chk("PWDATA", PWDATA, m_wdata);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_rdata", rsp_rdata, m_rd);
        chk("rsp_err", rsp_err, m_re);
    end

    task automatic do_cmd(input logic w, input logic [8:0] a, input logic [7:0] d, input int wt,
                          output int lat, output logic [7:0] rd, output logic er,
                          output int p1, output int p2, output logic rdy);
        int n = 0;
        lat = -1; rd = 0; er = 0; p1 = 0; p2 = 0; rdy = 0;
        @(negedge PCLK); #1;
        fix_wait = wt; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
        while (!cmd_ready && n < 40) begin @(negedge PCLK); #1; n++; end
        @(negedge PCLK);
        p1 += int'(PSEL1); p2 += int'(PSEL2);
        #1 cmd_valid = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err; rdy = cmd_ready;
                break;
            end
            p1 += int'(PSEL1); p2 += int'(PSEL2);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int lat, p1, p2, na, nr, n, acc[3];
    logic [7:0] rd;
    logic er, rdy, take, pen_seen;
    initial begin
        @(negedge PCLK); @(negedge PCLK); #1 PRESET = 0;
        @(negedge PCLK);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_psel1", PSEL1, 0);
        chk("reset_rsp_valid", rsp_valid, 0);

        do_cmd(1, 9'h005, 8'hA5, 0, lat, rd, er, p1, p2, rdy);
        chk("wr_lat", lat, 2); chk("wr_err", er, 0); chk("wr_rdata", rd, 0);
        chk("wr_psel1_cycles", p1, 2); chk("wr_psel2_cycles", p2, 0);

        do_cmd(1, 9'h105, 8'h3C, 0, lat, rd, er, p1, p2, rdy);
        chk("wr2_lat", lat, 2);
        do_cmd(0, 9'h105, 8'h00, 0, lat, rd, er, p1, p2, rdy);
        chk("rd2_lat", lat, 2); chk("rd2_rdata", rd, 8'h3C);
        chk("rd2_psel1_cycles", p1, 0); chk("rd2_psel2_cycles", p2, 2);

        do_cmd(0, 9'h005, 8'h00, 4, lat, rd, er, p1, p2, rdy);
        chk("wait4_lat", lat, 6); chk("wait4_err", er, 0); chk("wait4_rdata", rd, 8'hA5);

        do_cmd(0, 9'h105, 8'h00, 255, lat, rd, er, p1, p2, rdy);
        chk("tmo_lat", lat, 17); chk("tmo_err", er, 1); chk("tmo_rdata", rd, 0); chk("tmo_ready", rdy, 1);

        do_cmd(0, 9'h105, 8'h00, 15, lat, rd, er, p1, p2, rdy);
        chk("edge15_lat", lat, 17); chk("edge15_err", er, 0); chk("edge15_rdata", rd, 8'h3C);
        do_cmd(0, 9'h105, 8'h00, 16, lat, rd, er, p1, p2, rdy);
        chk("edge16_lat", lat, 17); chk("edge16_err", er, 1);

        rand_mode = 0; fix_wait = 0; na = 0; nr = 0;
        @(negedge PCLK); #1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 9'h020; cmd_wdata = 8'h60;
        for (int c = 0; c < 14; c++) begin
            nr += int'(rsp_valid);
            take = cmd_ready && cmd_valid;
            if (take && na < 3) begin acc[na] = c; na++; end
            @(negedge PCLK); #1;
            if (take) begin
                if (na < 3) begin cmd_addr = 9'(32 + na); cmd_wdata = 8'(96 + na); end
                else cmd_valid = 0;
            end
        end
        chk("b2b_accepts", na, 3); chk("b2b_responses", nr, 3);
        chk("b2b_gap1", acc[1] - acc[0], 3); chk("b2b_gap2", acc[2] - acc[1], 3);

        fix_wait = 8; cmd_write = 0; cmd_addr = 9'h010; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 40) begin @(negedge PCLK); #1; n++; end
        @(negedge PCLK); #1 cmd_valid = 0;
        n = 0;
        while (!PENABLE && n < 10) begin @(negedge PCLK); n++; end
        @(negedge PCLK);
        pen_seen = PENABLE;
        #1 PRESET = 1;
        #1;
        chk("rst_pen_before", pen_seen, 1);
        chk("rst_psel1", PSEL1, 0); chk("rst_psel2", PSEL2, 0);
        chk("rst_penable", PENABLE, 0); chk("rst_rsp_valid", rsp_valid, 0);
        #1 PRESET = 0;
        nr = 0;
        repeat (10) begin @(negedge PCLK); nr += int'(rsp_valid); end
        chk("rst_no_rsp", nr, 0);
        do_cmd(1, 9'h033, 8'h77, 0, lat, rd, er, p1, p2, rdy);
        chk("post_rst_wr_lat", lat, 2); chk("post_rst_wr_err", er, 0);
        do_cmd(0, 9'h033, 8'h00, 0, lat, rd, er, p1, p2, rdy);
        chk("post_rst_rd_lat", lat, 2); chk("post_rst_rd_rdata", rd, 8'h77);

        rand_mode = 1;
        repeat (700) begin
            @(negedge PCLK); #1;
            cmd_valid = $urandom_range(2) != 0;
            cmd_write = 1'($urandom);
            cmd_addr  = {1'($urandom), 8'($urandom_range(15))};
            cmd_wdata = 8'($urandom);
        end
        @(negedge PCLK); #1 cmd_valid = 0;
        n = 0;
        while (!cmd_ready && n < 40) begin @(negedge PCLK); n++; end
        chk("final_idle", cmd_ready, 1);
        repeat (3) @(negedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
